// File: rtl/button_event_arbiter.sv
// Four-channel button press arbiter: edge-detects presses, queues one pending
// flag per channel and presents them round-robin through a valid/ready slot.
module button_event_arbiter (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] btn,
   input  logic       evt_ready,
   output logic       evt_valid,
   output logic [1:0] evt_id,
   output logic [3:0] pending,
   output logic       overflow
);

   logic [3:0] btn_q;
   logic [3:0] pending_q, pending_d;
   logic       valid_q, valid_d;
   logic [1:0] id_q, id_d;
   logic [1:0] last_q, last_d;
   logic       ovf_q, ovf_d;

   logic [3:0] press;
   logic [3:0] clr;
   logic       slot_free;
   logic       found;
   logic       load;
   logic [1:0] sel;
   logic [1:0] idx;

   always_comb begin
      press     = btn & ~btn_q;
      slot_free = ~valid_q | evt_ready;

      // Search starts one past the last grant; offset 4 wraps back to last_q itself.
      sel   = last_q;
      found = 1'b0;
      idx   = 2'd0;
      for (int off = 1; off <= 4; off++) begin
         idx = last_q + 2'(off);
         if (!found && pending_q[idx]) begin
            sel   = idx;
            found = 1'b1;
         end
      end

      load = slot_free & found;
      clr  = load ? (4'b0001 << sel) : 4'b0000;

      // A press landing on the bit being cleared this edge re-arms it, no drop.
      pending_d = (pending_q & ~clr) | press;
      ovf_d     = |(press & pending_q & ~clr);

      valid_d = slot_free ? found : valid_q;
      id_d    = load ? sel : id_q;
      last_d  = load ? sel : last_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         btn_q     <= 4'b0000;
         pending_q <= 4'b0000;
         valid_q   <= 1'b0;
         id_q      <= 2'd0;
         last_q    <= 2'd3;
         ovf_q     <= 1'b0;
      end else begin
         btn_q     <= btn;
         pending_q <= pending_d;
         valid_q   <= valid_d;
         id_q      <= id_d;
         last_q    <= last_d;
         ovf_q     <= ovf_d;
      end
   end

   assign evt_valid = valid_q;
   assign evt_id    = id_q;
   assign pending   = pending_q;
   assign overflow  = ovf_q;

endmodule
